draw_scheduler: RTL

Frame-level draw scheduler that shares the single VGA write port between up to four sprite/plane drawers (for example background, link, the enemies group, HUD). On a frame request from game control it starts each enabled drawer in fixed order, waits for that drawer's done, and multiplexes only the active drawer's pixel stream onto the VGA port. It then reports frame completion. It replaces ad-hoc per-module draw chaining with one sequenced owner of the VGA port, and adds a watchdog so a hung drawer cannot stall the frame.

---
 rtl/draw_scheduler_if.sv | 42 ++++
 rtl/draw_scheduler.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/draw_scheduler_if.sv
// rtl/draw_scheduler_if.sv - bus between game control, the sprite drawers and the VGA write port
//
// Purpose: bundles every draw_scheduler signal except clock and reset.
//   slave  : the scheduler side (takes requests and client streams, drives VGA and status)
//   master : the controller/drawer side (drives requests and client streams)
// Signals:
//   frame_start, enable_mask                      frame request from game control
//   client_done, client_x/y/colour, client_write  per-client streams, packed 4 wide
//   client_start                                  one-hot start pulse to the clients
//   x_draw, y_draw, colour, VGA_write             muxed VGA write port
//   busy, frame_done, timeout_flag                scheduler status
interface draw_scheduler_if;
    logic        frame_start;
    logic [3:0]  enable_mask;
    logic [3:0]  client_done;
    logic [35:0] client_x;
    logic [31:0] client_y;
    logic [23:0] client_colour;
    logic [3:0]  client_write;
    logic [3:0]  client_start;
    logic [8:0]  x_draw;
    logic [7:0]  y_draw;
    logic [5:0]  colour;
    logic        VGA_write;
    logic        busy;
    logic        frame_done;
    logic        timeout_flag;

    modport slave (
        input  frame_start, enable_mask, client_done, client_x, client_y,
               client_colour, client_write,
        output client_start, x_draw, y_draw, colour, VGA_write, busy,
               frame_done, timeout_flag
    );

    modport master (
        output frame_start, enable_mask, client_done, client_x, client_y,
               client_colour, client_write,
        input  client_start, x_draw, y_draw, colour, VGA_write, busy,
               frame_done, timeout_flag
    );
endinterface

// File: rtl/draw_scheduler.sv
// rtl/draw_scheduler.sv - frame-level sequencer sharing one VGA write port between four drawers
//
// Purpose: on frame_start, starts each enabled client in order 0..3, waits for its
// done (or a TIMEOUT-cycle watchdog), routes only the active client onto the VGA
// port, then pulses frame_done.
// Ports:
//   clock   rising-edge system clock
//   reset   synchronous, active-high
//   bus     draw_scheduler_if.slave (frame request, client streams, VGA port, status)
// Parameter:
//   TIMEOUT maximum WAIT cycles per client before it is abandoned
module draw_scheduler #(
    parameter logic [15:0] TIMEOUT = 16'd40000
) (
    input  logic             clock,
    input  logic             reset,
    draw_scheduler_if.slave  bus
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SELECT,
        S_START,
        S_WAIT,
        S_DONE
    } state_t;

    state_t      state;
    state_t      state_nx;
    logic [2:0]  idx;
    logic [3:0]  mask_q;
    logic [15:0] timer;
    logic        timeout_q;

    // idx only reaches 4 in SELECT, where it is tested before sel is used,
    // so the low two bits are always a valid client number when sel matters.
    logic [1:0]  sel;
    logic        idx_end;
    logic        active_done;
    logic        timer_expired;

    assign sel           = idx[1:0];
    assign idx_end       = (idx == 3'd4);
    assign active_done   = bus.client_done[sel];
    assign timer_expired = (timer == TIMEOUT - 16'd1);

    // State register and datapath registers
    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= S_IDLE;
            idx       <= 3'd0;
            mask_q    <= 4'd0;
            timer     <= 16'd0;
            timeout_q <= 1'b0;
        end else begin
            state <= state_nx;
            case (state)
                S_IDLE: begin
                    if (bus.frame_start) begin
                        mask_q    <= bus.enable_mask;
                        idx       <= 3'd0;
                        timeout_q <= 1'b0;
                    end
                end
                S_SELECT: begin
                    // Disabled clients are skipped one per cycle; idx stops at 4.
                    if (!idx_end && !mask_q[sel]) begin
                        idx <= idx + 3'd1;
                    end
                end
                S_START: begin
                    timer <= 16'd0;
                end
                S_WAIT: begin
                    timer <= timer + 16'd1;
                    // done takes priority, so a late done never raises the flag
                    if (active_done) begin
                        idx <= idx + 3'd1;
                    end else if (timer_expired) begin
                        timeout_q <= 1'b1;
                        idx       <= idx + 3'd1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Next-state logic
    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE: begin
                if (bus.frame_start) begin
                    state_nx = S_SELECT;
                end
            end
            S_SELECT: begin
                if (idx_end) begin
                    state_nx = S_DONE;
                end else if (mask_q[sel]) begin
                    state_nx = S_START;
                end
            end
            S_START: begin
                state_nx = S_WAIT;
            end
            S_WAIT: begin
                if (active_done || timer_expired) begin
                    state_nx = S_SELECT;
                end
            end
            S_DONE: begin
                state_nx = S_IDLE;
            end
            default: begin
                state_nx = S_IDLE;
            end
        endcase
    end

    // Outputs: VGA mux is live only in WAIT, so idle or skipped clients never write
    always_comb begin
        bus.client_start = 4'd0;
        bus.x_draw       = 9'd0;
        bus.y_draw       = 8'd0;
        bus.colour       = 6'd0;
        bus.VGA_write    = 1'b0;
        bus.frame_done   = 1'b0;
        bus.busy         = (state != S_IDLE);
        bus.timeout_flag = timeout_q;
        case (state)
            S_START: begin
                bus.client_start[sel] = 1'b1;
            end
            S_WAIT: begin
                bus.x_draw    = bus.client_x[sel * 9 +: 9];
                bus.y_draw    = bus.client_y[sel * 8 +: 8];
                bus.colour    = bus.client_colour[sel * 6 +: 6];
                bus.VGA_write = bus.client_write[sel];
            end
            S_DONE: begin
                bus.frame_done = 1'b1;
            end
            default: begin
            end
        endcase
    end

endmodule
